// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared constants and helpers for the multi-channel programmable
//            clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Smallest divisor that produces a running output; anything below disables.
    localparam int DIV_MIN = 2;

    // Width of a channel-select field for n channels (never narrower than 1).
    function automatic int CH_SEL_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // High-phase length of a period: ceil(a/2). Carried at 33 bits so a full
    // 32-bit divisor cannot overflow the +1.
    function automatic logic [32:0] ceil_half(input logic [32:0] a);
        return (a + 33'd1) >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_chan
// Brief    : One divider channel. Holds the shadow divisor, the active
//            divisor, the phase counter and the registered outputs. Divisor
//            changes only land on a period boundary or a sync.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             sync_i,
    output logic             div_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [DIV_W-1:0] c_default_div = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_div_min     = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] c_one         = DIV_W'(1);
    // Counter parked on the last phase so the first edge out of reset wraps.
    localparam logic [DIV_W-1:0] c_reset_cnt   =
        (DEFAULT_DIV >= DIV_MIN) ? DIV_W'(DEFAULT_DIV - 1) : '0;

    logic [DIV_W-1:0] r_shadow;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_cnt;
    logic             r_div;
    logic             r_tick;
    logic             r_pending;

    logic [DIV_W-1:0] w_shadow_eff;
    logic             w_enabled;
    logic             w_wrap;
    logic             w_restart;
    logic [DIV_W-1:0] w_active_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_run_nxt;
    logic             w_div_nxt;
    logic             w_tick_nxt;

    // Next-state: pick the divisor and phase for the coming cycle.
    always_comb begin
        w_shadow_eff = we_i ? div_i : r_shadow;
        w_enabled    = (r_active >= c_div_min);
        w_wrap       = w_enabled && (r_cnt >= (r_active - c_one));
        w_active_nxt = r_active;
        w_cnt_nxt    = r_cnt + c_one;
        w_restart    = 1'b0;
        if (sync_i) begin
            // Forced boundary; a same-cycle write is taken immediately.
            w_active_nxt = w_shadow_eff;
            w_restart    = 1'b1;
        end else if (!w_enabled) begin
            // Idle channel follows the stored shadow; a newly stored valid
            // divisor therefore starts the channel one edge after the write.
            w_active_nxt = r_shadow;
            w_restart    = 1'b1;
        end else if (w_wrap) begin
            w_active_nxt = w_shadow_eff;
            w_restart    = 1'b1;
        end
        if (w_restart) begin
            w_cnt_nxt = '0;
        end
        w_run_nxt  = (w_active_nxt >= c_div_min);
        w_div_nxt  = w_run_nxt && (33'(w_cnt_nxt) < ceil_half(33'(w_active_nxt)));
        w_tick_nxt = w_run_nxt && (w_cnt_nxt == '0);
    end

    // State and output registers; reset drops outputs asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shadow  <= c_default_div;
            r_active  <= c_default_div;
            r_cnt     <= c_reset_cnt;
            r_div     <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_shadow  <= w_shadow_eff;
            r_active  <= w_active_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_tick    <= w_tick_nxt;
            r_pending <= (w_shadow_eff != w_active_nxt);
        end
    end

    assign div_o     = r_div;
    assign tick_o    = r_tick;
    assign pending_o = r_pending;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi_prog
// Brief    : N_CH independent programmable clock dividers with a shared
//            configuration port and a global phase re-alignment strobe.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi_prog
    import clk_div_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        cfg_we_i,
    input  logic [CH_SEL_W(N_CH)-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]            cfg_div_i,
    input  logic                        sync_i,
    output logic [N_CH-1:0]             div_o,
    output logic [N_CH-1:0]             tick_o,
    output logic [N_CH-1:0]             pending_o
);

    localparam int c_ch_w = CH_SEL_W(N_CH);

    // Channel selects beyond N_CH-1 match no instance and are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic w_we;
        assign w_we = cfg_we_i && (cfg_ch_i == c_ch_w'(i));

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .we_i      (w_we),
            .div_i     (cfg_div_i),
            .sync_i    (sync_i),
            .div_o     (div_o[i]),
            .tick_o    (tick_o[i]),
            .pending_o (pending_o[i])
        );
    end

endmodule
`default_nettype wire
